// File: rtl/wb_stage_if.sv
// wb_stage_if: stage-4/stage-5 handshake, data-cache return and register-file write port
interface wb_stage_if;
  logic [31:0] I3, alu3, link3, dmem_rdata, I4, rf_wdata;
  logic valid3, stall, dmem_ready, wb_busy, rf_we;
  logic [2:0] WBsel;
  logic [4:0] rf_waddr;
  modport master (output I3, valid3, stall, alu3, link3, dmem_rdata, dmem_ready, WBsel,
                  input I4, wb_busy, rf_we, rf_waddr, rf_wdata);
  modport slave (input I3, valid3, stall, alu3, link3, dmem_rdata, dmem_ready, WBsel,
                 output I4, wb_busy, rf_we, rf_waddr, rf_wdata);
endinterface

// File: rtl/wb_stage.sv
// wb_stage: minicpu write-back stage with load-wait FSM and single-shot register write
// WB_ALIGN_EN: when defined, big-endian sub-word load alignment and extension
module wb_stage (
  input logic clk,
  input logic reset_n,
  wb_stage_if.slave bus
);
  localparam logic [1:0] RUN = 2'd0, WAIT = 2'd1, COMMIT = 2'd2;
  localparam logic [2:0] select_wb_alu = 3'd0, select_wb_link = 3'd1, select_wb_load = 3'd2;
  logic [1:0] state;
  logic [31:0] alu4, link4, lmdr, ld;
  logic committed, adv, is_load3, is_link4, wr, we;
  logic [5:0] op4, fn4;
  logic [4:0] rt4, rd4;
  assign op4 = bus.I4[31:26];
  assign rt4 = bus.I4[20:16];
  assign rd4 = bus.I4[15:11];
  assign fn4 = bus.I4[5:0];
  assign is_load3 = bus.valid3 && (bus.I3[31:26] inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25});
  assign is_link4 = op4 == 6'h03 || (op4 == 6'h01 && rt4 inside {5'h10, 5'h11});
  assign wr = op4 == 6'h00 ? fn4 != 6'h08
            : is_link4 || (op4 inside {[6'h08:6'h0f], 6'h20, 6'h21, 6'h23, 6'h24, 6'h25});
  assign bus.rf_waddr = op4 == 6'h00 ? rd4 : is_link4 ? 5'd31 : rt4;
  assign we = bus.rf_waddr != 5'd0 && !committed && (state == RUN ? wr : state == COMMIT);
  assign bus.rf_we = we;
  assign bus.wb_busy = state == WAIT;
  assign adv = !bus.stall && state != WAIT;
`ifdef WB_ALIGN_EN
  logic [7:0] b;
  logic [15:0] h;
  logic sx;
  always_comb begin
    b = 8'(lmdr >> {~alu4[1:0], 3'b000});
    h = alu4[1] ? lmdr[15:0] : lmdr[31:16];
    sx = !op4[2];
    ld = op4[1:0] == 2'b11 ? lmdr : op4[0] ? {{16{sx & h[15]}}, h} : {{24{sx & b[7]}}, b};
  end
`else
  assign ld = lmdr;
`endif
  assign bus.rf_wdata = bus.WBsel == select_wb_link ? link4 : bus.WBsel == select_wb_load ? ld : alu4;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.I4 <= '0;
      alu4 <= '0;
      link4 <= '0;
      lmdr <= '0;
      committed <= 1'b0;
      state <= RUN;
    end else if (adv) begin
      bus.I4 <= bus.valid3 ? bus.I3 : '0;
      alu4 <= bus.alu3;
      link4 <= bus.link3;
      committed <= 1'b0;
      state <= is_load3 ? WAIT : RUN;
    end else begin
      if (we) committed <= 1'b1;
      if (state == WAIT && bus.dmem_ready) begin
        lmdr <= bus.dmem_rdata;
        state <= COMMIT;
      end
    end
endmodule
